// File: rtl/id_stage_ctrl_pkg.sv
// Shared core definitions: immediate-type selects, RV64 opcodes, decoded-field
// struct and the decode stage state encoding.
package id_stage_ctrl_pkg;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_SB   = 3'b010;
  localparam logic [2:0] IMM_U    = 3'b011;
  localparam logic [2:0] IMM_UJ   = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b111;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  typedef struct packed {
    logic [2:0] imm_type;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       uses_rd;
    logic       illegal;
  } decode_t;

  // What an empty stage presents: no immediate, no fields, not illegal.
  localparam decode_t DECODE_EMPTY   = '{IMM_NONE, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam decode_t DECODE_ILLEGAL = '{IMM_NONE, 1'b0, 1'b0, 1'b0, 1'b1};

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_t;

endpackage

// File: rtl/id_stage_ctrl_opcode_decoder.sv
// Combinational opcode decode: immediate type, register-field usage and the
// illegal-opcode flag.
module opcode_decoder
  import id_stage_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output decode_t    dec
);

  always_comb begin
    dec = DECODE_ILLEGAL;
    case (opcode)
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM:
        dec = '{IMM_I, 1'b1, 1'b0, 1'b1, 1'b0};
      OP_STORE:
        dec = '{IMM_S, 1'b1, 1'b1, 1'b0, 1'b0};
      OP_BRANCH:
        dec = '{IMM_SB, 1'b1, 1'b1, 1'b0, 1'b0};
      OP_LUI, OP_AUIPC:
        dec = '{IMM_U, 1'b0, 1'b0, 1'b1, 1'b0};
      OP_JAL:
        dec = '{IMM_UJ, 1'b0, 1'b0, 1'b1, 1'b0};
      // R-type has no immediate but uses all three register fields
      OP_OP, OP_OP32:
        dec = '{IMM_NONE, 1'b1, 1'b1, 1'b1, 1'b0};
      default:
        dec = DECODE_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode stage controller: IF/ID register with registered decode, load-use
// hazard bubble, flush and valid/ready handshakes toward fetch and execute.
module id_stage_ctrl
  import id_stage_ctrl_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_ready,
  output logic             id_valid,
  input  logic             ex_ready,
  output logic [31:0]      id_instr,
  output logic [XLEN-1:0]  id_pc,
  output logic [2:0]       id_imm_type,
  output logic [4:0]       id_rs1,
  output logic [4:0]       id_rs2,
  output logic [4:0]       id_rd,
  output logic             id_illegal,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_state_t     state_q;
  logic [31:0]      instr_q;
  logic [XLEN-1:0]  pc_q;
  decode_t          dec_q;
  logic [4:0]       rs1_q, rs2_q, rd_q;
  logic [CNT_W-1:0] cnt_q;

  decode_t dec_new;
  logic    valid_q, hazard, out_fire, in_fire;

  opcode_decoder u_opcode_decoder (
    .opcode (if_instr[6:0]),
    .dec    (dec_new)
  );

  assign valid_q  = (state_q == ST_FULL);
  assign hazard   = valid_q & ex_mem_read & (ex_rd != 5'd0) &
                    ((dec_q.uses_rs1 & (rs1_q == ex_rd)) |
                     (dec_q.uses_rs2 & (rs2_q == ex_rd)));
  assign id_valid = valid_q & ~hazard;
  assign out_fire = id_valid & ex_ready;
  assign if_ready = ~rst & ~flush & ~hazard & (~valid_q | out_fire);
  assign in_fire  = if_valid & if_ready;

  assign id_instr    = instr_q;
  assign id_pc       = pc_q;
  assign id_imm_type = dec_q.imm_type;
  assign id_illegal  = dec_q.illegal;
  assign id_rs1      = rs1_q;
  assign id_rs2      = rs2_q;
  assign id_rd       = rd_q;
  assign stall_cnt   = cnt_q;

  // Flush beats refill beats drain; leaving FULL clears the decode so an
  // empty stage always shows IMM_NONE and zero register fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      instr_q <= '0;
      pc_q    <= '0;
      dec_q   <= DECODE_EMPTY;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      if (hazard && !flush && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + CNT_W'(1);

      if (flush || (out_fire && !in_fire)) begin
        state_q <= ST_EMPTY;
        dec_q   <= DECODE_EMPTY;
        rs1_q   <= '0;
        rs2_q   <= '0;
        rd_q    <= '0;
      end else if (in_fire) begin
        state_q <= ST_FULL;
        instr_q <= if_instr;
        pc_q    <= if_pc;
        dec_q   <= dec_new;
        rs1_q   <= dec_new.uses_rs1 ? if_instr[19:15] : 5'd0;
        rs2_q   <= dec_new.uses_rs2 ? if_instr[24:20] : 5'd0;
        rd_q    <= dec_new.uses_rd  ? if_instr[11:7]  : 5'd0;
      end
    end
  end

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Self-checking bench for id_stage_ctrl: directed vector table, flush/hazard
// and counter-saturation sequences, then randomized traffic against a model.
module tb_id_stage_ctrl;

  localparam int XLEN = 64;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_LUI  = 32'h123452B7;
  localparam logic [31:0] I_JAL  = 32'h000000EF;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  logic            clk = 1'b0;
  logic            rst, if_valid, ex_ready, ex_mem_read, flush;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic [4:0]      ex_rd;
  logic            if_ready, id_valid, id_illegal;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic [2:0]      id_imm_type;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic [15:0]     stall_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: what the stage holds, at the instruction level.
  bit          m_valid = 0;
  logic [31:0] m_instr = '0;
  logic [63:0] m_pc    = '0;
  int          m_cnt   = 0;

  id_stage_ctrl #(.XLEN(XLEN), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .id_valid(id_valid), .ex_ready(ex_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_imm_type(id_imm_type), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_illegal(id_illegal), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, if_valid;
    logic [31:0] instr;
    logic        ex_ready, mem_read;
    logic [4:0]  ex_rd;
    logic        flush;
    logic        e_if_ready, e_id_valid;
    logic [2:0]  e_imm;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic        e_ill;
    logic [15:0] e_cnt;
    logic [31:0] e_instr;
  } vec_t;

  function automatic vec_t mk(logic r, logic v, logic [31:0] ins, logic er, logic mr,
                              logic [4:0] xr, logic fl, logic eir, logic eiv, logic [2:0] eimm,
                              logic [4:0] e1, logic [4:0] e2, logic [4:0] ed, logic eil,
                              logic [15:0] ec, logic [31:0] ei);
    vec_t t;
    t.rst = r; t.if_valid = v; t.instr = ins; t.ex_ready = er; t.mem_read = mr;
    t.ex_rd = xr; t.flush = fl; t.e_if_ready = eir; t.e_id_valid = eiv; t.e_imm = eimm;
    t.e_rs1 = e1; t.e_rs2 = e2; t.e_rd = ed; t.e_ill = eil; t.e_cnt = ec; t.e_instr = ei;
    return t;
  endfunction

  // Instruction-format view of the opcode map.
  function automatic void refDecode(input logic [31:0] ins, output logic [2:0] imm,
                                    output bit u1, output bit u2, output bit ud, output bit ill);
    byte fmt;
    case (ins[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: fmt = "I";
      7'b0100011:             fmt = "S";
      7'b1100011:             fmt = "B";
      7'b0110111, 7'b0010111: fmt = "U";
      7'b1101111:             fmt = "J";
      7'b0110011, 7'b0111011: fmt = "R";
      default:                fmt = "X";
    endcase
    imm = (fmt == "I") ? 3'd0 : (fmt == "S") ? 3'd1 : (fmt == "B") ? 3'd2 :
          (fmt == "U") ? 3'd3 : (fmt == "J") ? 3'd4 : 3'd7;
    u1  = fmt inside {"I", "S", "B", "R"};
    u2  = fmt inside {"S", "B", "R"};
    ud  = fmt inside {"I", "U", "J", "R"};
    ill = (fmt == "X");
  endfunction

  function automatic void modelComb(output bit hz, output bit iv, output bit ir);
    logic [2:0] imm;
    bit u1, u2, ud, ill;
    refDecode(m_instr, imm, u1, u2, ud, ill);
    hz = m_valid && ex_mem_read && (ex_rd != 0) &&
         ((u1 && m_instr[19:15] == ex_rd) || (u2 && m_instr[24:20] == ex_rd));
    iv = m_valid && !hz;
    ir = !rst && !flush && !hz && (!m_valid || (iv && ex_ready));
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input logic [63:0] pc);
    @(negedge clk);
    rst = v.rst; if_valid = v.if_valid; if_instr = v.instr; if_pc = pc;
    ex_ready = v.ex_ready; ex_mem_read = v.mem_read; ex_rd = v.ex_rd; flush = v.flush;
    #1;
  endtask

  task automatic checkOutput(input string tag);
    logic [2:0] imm;
    bit u1, u2, ud, ill, hz, iv, ir;
    refDecode(m_instr, imm, u1, u2, ud, ill);
    modelComb(hz, iv, ir);
    cmp({tag, " if_ready"}, 64'(if_ready), 64'(ir));
    cmp({tag, " id_valid"}, 64'(id_valid), 64'(iv));
    cmp({tag, " imm_type"}, 64'(id_imm_type), 64'(m_valid ? imm : 3'd7));
    cmp({tag, " rs1"}, 64'(id_rs1), 64'((m_valid && u1) ? m_instr[19:15] : 5'd0));
    cmp({tag, " rs2"}, 64'(id_rs2), 64'((m_valid && u2) ? m_instr[24:20] : 5'd0));
    cmp({tag, " rd"}, 64'(id_rd), 64'((m_valid && ud) ? m_instr[11:7] : 5'd0));
    cmp({tag, " illegal"}, 64'(id_illegal), 64'(m_valid && ill));
    cmp({tag, " stall_cnt"}, 64'(stall_cnt), 64'(m_cnt));
    if (m_valid) begin
      cmp({tag, " id_instr"}, 64'(id_instr), 64'(m_instr));
      cmp({tag, " id_pc"}, id_pc, m_pc);
    end
  endtask

  task automatic advanceClock();
    bit hz, iv, ir, outf, inf, r, fl;
    logic [31:0] ins;
    logic [63:0] pc;
    modelComb(hz, iv, ir);
    outf = iv && ex_ready;
    inf  = if_valid && ir;
    r = rst; fl = flush; ins = if_instr; pc = if_pc;
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_instr = '0; m_pc = '0; m_cnt = 0;
    end else begin
      if (hz && !fl) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
      if (fl)        m_valid = 0;
      else if (inf)  begin m_valid = 1; m_instr = ins; m_pc = pc; end
      else if (outf) m_valid = 0;
    end
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    rst = 1; if_valid = 0; if_instr = '0; if_pc = '0;
    ex_ready = 0; ex_mem_read = 0; ex_rd = '0; flush = 0;
    @(posedge clk);

    //          rst v  instr   er mr xrd fl | ir iv imm rs1 rs2 rd ill cnt instr
    tbl.push_back(mk(1, 0, 32'h0, 0, 0, 0, 0,  0, 0, 7, 0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, I_ADDI, 1, 0, 0, 0, 1, 0, 7, 0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, I_SW,   1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, I_ADDI));
    tbl.push_back(mk(0, 1, I_BEQ,  1, 0, 0, 0, 1, 1, 1, 1, 2, 0, 0, 0, I_SW));
    tbl.push_back(mk(0, 1, I_LUI,  1, 0, 0, 0, 1, 1, 2, 1, 2, 0, 0, 0, I_BEQ));
    tbl.push_back(mk(0, 1, I_JAL,  1, 0, 0, 0, 1, 1, 3, 0, 0, 5, 0, 0, I_LUI));
    tbl.push_back(mk(0, 1, I_ADD,  1, 0, 0, 0, 1, 1, 4, 0, 0, 1, 0, 0, I_JAL));
    tbl.push_back(mk(0, 0, 32'h0,  1, 1, 2, 0, 0, 0, 7, 1, 2, 3, 0, 0, I_ADD));
    tbl.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0, 1, 7, 1, 2, 3, 0, 1, I_ADD));
    tbl.push_back(mk(0, 1, I_ADDI, 0, 0, 0, 0, 0, 1, 7, 1, 2, 3, 0, 1, I_ADD));
    tbl.push_back(mk(0, 1, I_ADDI, 0, 0, 0, 0, 0, 1, 7, 1, 2, 3, 0, 1, I_ADD));
    tbl.push_back(mk(0, 1, I_ILL,  1, 0, 0, 1, 0, 1, 7, 1, 2, 3, 0, 1, I_ADD));
    tbl.push_back(mk(0, 1, I_ILL,  0, 0, 0, 0, 1, 0, 7, 0, 0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,  1, 0, 0, 0, 1, 1, 7, 0, 0, 0, 1, 1, I_ILL));
    tbl.push_back(mk(0, 0, 32'h0,  1, 0, 0, 0, 1, 0, 7, 0, 0, 0, 0, 1, 32'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      string t;
      t = $sformatf("row%0d", i);
      applyStimulus(tbl[i], 64'h1000 + 64'(4 * i));
      cmp({t, " tbl if_ready"}, 64'(if_ready), 64'(tbl[i].e_if_ready));
      cmp({t, " tbl id_valid"}, 64'(id_valid), 64'(tbl[i].e_id_valid));
      cmp({t, " tbl imm_type"}, 64'(id_imm_type), 64'(tbl[i].e_imm));
      cmp({t, " tbl rs1"}, 64'(id_rs1), 64'(tbl[i].e_rs1));
      cmp({t, " tbl rs2"}, 64'(id_rs2), 64'(tbl[i].e_rs2));
      cmp({t, " tbl rd"}, 64'(id_rd), 64'(tbl[i].e_rd));
      cmp({t, " tbl illegal"}, 64'(id_illegal), 64'(tbl[i].e_ill));
      cmp({t, " tbl stall_cnt"}, 64'(stall_cnt), 64'(tbl[i].e_cnt));
      if (tbl[i].e_id_valid) cmp({t, " tbl id_instr"}, 64'(id_instr), 64'(tbl[i].e_instr));
      if (i == 0) begin
        cmp("reset id_instr", 64'(id_instr), 64'h0);
        cmp("reset id_pc", id_pc, 64'h0);
      end
      checkOutput({t, " model"});
      advanceClock();
    end

    // Flush coinciding with a hazard: stage empties, counter does not move.
    v = mk(0, 1, I_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(v, 64'h2000); checkOutput("fh load"); advanceClock();
    v = mk(0, 1, I_SW, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(v, 64'h2004); checkOutput("fh flush"); advanceClock();
    v = mk(0, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(v, 64'h2008); checkOutput("fh after");
    cmp("fh stall_cnt held", 64'(stall_cnt), 64'd1);
    advanceClock();

    // Counter saturation: hold a load-use hazard past 2^16 cycles.
    v = mk(0, 1, I_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(v, 64'h3000); checkOutput("sat load"); advanceClock();
    v = mk(0, 0, 32'h0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(v, 64'h3004); checkOutput("sat start"); advanceClock();
    begin
      int n;
      n = 65534 - m_cnt;
      repeat (n) @(posedge clk);
      m_cnt = m_cnt + n;
    end
    for (int k = 0; k < 6; k++) begin
      applyStimulus(v, 64'h3004); checkOutput($sformatf("sat %0d", k)); advanceClock();
    end
    applyStimulus(v, 64'h3004);
    cmp("sat stall_cnt", 64'(stall_cnt), 64'hFFFF);
    advanceClock();

    // Random traffic with small register numbers so hazards are frequent.
    begin
      logic [6:0] ops[13];
      ops = '{7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011, 7'b0100011,
              7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0111011,
              7'b1111111};
      for (int c = 0; c < 3000; c++) begin
        vec_t rv;
        logic [31:0] ins;
        int sel;
        ins = $urandom;
        sel = $urandom_range(0, 13);
        ins[6:0]   = (sel == 13) ? 7'($urandom) : ops[sel];
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        rv = mk((c == 0) || ($urandom_range(0, 99) < 2), 1'($urandom), ins,
                ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 40),
                5'($urandom_range(0, 3)), ($urandom_range(0, 99) < 8),
                0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(rv, {32'($urandom), 32'($urandom)});
        checkOutput($sformatf("rand%0d", c));
        advanceClock();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage_ctrl.md
# id_stage_ctrl

Instruction-decode stage controller for the pipelined RISC-V core. It owns the IF/ID pipeline register and decodes each captured instruction's opcode into the 3-bit immediate-type select for the downstream sign-extension unit. It also generates source/destination register fields, detects load-use hazards and holds the stage with a bubble when needed. It applies flushes and runs a valid/ready handshake toward both fetch and execute.

## Interface
- `XLEN`, 64, PC width.
- `CNT_W`, 16, width of the saturating stall counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_valid` in 1: fetch offers an instruction.
- `if_instr` in 32: offered instruction.
- `if_pc` in XLEN: offered PC.
- `if_ready` out 1: stage accepts the offer this cycle.
- `id_valid` out 1: decoded instruction is presented to EX.
- `ex_ready` in 1: EX accepts the presented instruction.
- `id_instr` out 32: held instruction, which feeds the sign-extension unit.
- `id_pc` out XLEN: held PC.
- `id_imm_type` out 3: immediate select. Encodings: 000 I, 001 S, 010 SB, 011 U, 100 UJ, 111 none.
- `id_rs1`, `id_rs2`, `id_rd` out 5 each: register fields. A field is forced to 0 when the format does not use it.
- `id_illegal` out 1: opcode not recognised.
- `ex_mem_read` in 1: instruction currently in EX is a load.
- `ex_rd` in 5: destination register of the instruction in EX.
- `flush` in 1: discard the stage contents (taken branch or jump).
- `stall_cnt` out CNT_W: number of hazard-stall cycles since reset, saturating.

## Operation
- Stage FSM has two states.
  - EMPTY: `valid_q`=0.
  - FULL: `valid_q`=1, holding `instr_q`, `pc_q` and the registered decode.
- Opcode map (`instr[6:0]`):
  - 0000011, 0010011, 0011011, 1100111, 1110011 → I.
  - 0100011 → S.
  - 1100011 → SB.
  - 0110111, 0010111 → U.
  - 1101111 → UJ.
  - 0110011, 0111011 → none, not illegal.
  - Any other opcode → none with `illegal`=1.
- The decode is computed from `if_instr` and registered on capture. Outputs are driven only from registers.
- Register-field usage:
  - `uses_rs1` is true for I, S, SB and R formats.
  - `uses_rs2` is true for S, SB and R formats.
  - `uses_rd` is true for I, U, UJ and R formats.
  - A field that is not used reads 0.
- `hazard` = `valid_q` & `ex_mem_read` & (`ex_rd`≠0) & ((`uses_rs1` & `rs1_q`==`ex_rd`) | (`uses_rs2` & `rs2_q`==`ex_rd`)).
- `id_valid` = `valid_q` & !`hazard`. A hazard presents a bubble to EX while the contents are held.
- `out_fire` = `id_valid` & `ex_ready`.
- `if_ready` = !`rst` & !`flush` & !`hazard` & (!`valid_q` | `out_fire`).
- `in_fire` = `if_valid` & `if_ready`.
- Next-state priority, highest first:
  - `rst` → EMPTY.
  - `flush` → EMPTY. The stage contents and any concurrent offer are both dropped.
  - `in_fire` → FULL with the new instruction. This covers simultaneous drain and refill.
  - `out_fire` → EMPTY.
  - Otherwise hold.
- `stall_cnt` increments on every cycle with `hazard` and no `flush`. It saturates at all-ones and never wraps. It is cleared only by `rst`.
- Reset values:
  - `valid_q`=0, so `id_valid`=0 and `if_ready`=0 during the reset cycle.
  - `id_instr`=0, `id_pc`=0, `id_imm_type`=111.
  - `id_rs1`/`id_rs2`/`id_rd`=0, `id_illegal`=0, `stall_cnt`=0.
- When in EMPTY, `id_imm_type` reads 111 and all register fields read 0.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is presented at `id_valid` after edge N.
- Throughput is one instruction per cycle when `ex_ready`=1 and no hazard occurs.
- `if_ready` and `id_valid` depend combinationally on `ex_ready`, `ex_mem_read`, `ex_rd` and `flush`. There is no combinational path from `if_valid` to any output.
- Once `id_valid` is asserted, `id_instr`, `id_pc` and the decode stay stable until `out_fire` or `flush`.
- A hazard lasts exactly as long as the EX inputs match. A typical load-use case costs one bubble cycle.
- A flush that coincides with a hazard or with `out_fire`: the flush wins, the state goes to EMPTY, and `stall_cnt` does not increment.
- Reset asserted mid-operation takes effect at the next edge regardless of the handshake.

## Structure
- The shared core package holds:
  - the imm_type constants (IMM_I, IMM_S, IMM_SB, IMM_U, IMM_UJ, IMM_NONE);
  - the opcode constants;
  - a struct for the decoded fields.
- The sign-extension unit uses the same imm_type constants.
- One combinational sub-module, `opcode_decoder`, maps an instruction to {imm_type, uses_rs1, uses_rs2, uses_rd, illegal}.
- The FSM, handshake logic and counter stay in `id_stage_ctrl`.

## Test plan
- Reset, then offer `addi x1,x0,5` (0x00500093) with `ex_ready`=1 → after one edge `id_valid`=1, `id_imm_type`=000, `id_rd`=1, `id_rs1`=0, `id_rs2`=0.
- Back-to-back sw, beq, lui, jal, add with `ex_ready`=1 → five consecutive accepted cycles; `id_imm_type` reads 001, 010, 011, 100, 111; `id_rd`=0 for sw and beq.
- Stage holds `add x3,x1,x2` while `ex_mem_read`=1 and `ex_rd`=2 for one cycle → `id_valid`=0 and `if_ready`=0 for that cycle, then `id_valid`=1 on the next; `stall_cnt`=1.
- `ex_ready`=0 for 3 cycles while FULL → `if_ready`=0 and `id_instr` is unchanged; `stall_cnt` is unchanged.
- `flush` together with `if_valid`=1 while FULL → next cycle EMPTY, `id_valid`=0, `id_imm_type`=111, and the offered instruction is not captured.
- Opcode 0x7F → `id_illegal`=1, `id_imm_type`=111. Separately, force 2^16+5 hazard cycles → `stall_cnt`=0xFFFF.
